// File: rtl/alarm_clock_pkg.sv
// Shared types and BCD digit limits for the alarm clock keypad and time-set paths.
package alarm_clock_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StEntry,
      StCommit
   } entry_state_e;

   localparam logic [3:0] MAX_MS_HR       = 4'd2;
   localparam logic [3:0] MAX_LS_HR_AT_20 = 4'd3;
   localparam logic [3:0] MAX_MS_MIN      = 4'd5;
   localparam logic [3:0] MAX_DIGIT       = 4'd9;

endpackage

// File: rtl/hhmm_validator.sv
// Combinational 24-hour HH:MM legality check on four BCD digits.
module hhmm_validator
   import alarm_clock_pkg::*;
(
   input  logic [3:0] ms_hr_i,
   input  logic [3:0] ls_hr_i,
   input  logic [3:0] ms_min_i,
   input  logic [3:0] ls_min_i,
   output logic       time_ok_o
);

   logic hr_ok;
   logic min_ok;

   // Hours 20-23 cap the low hour digit at 3.
   assign hr_ok  = (ms_hr_i <= MAX_MS_HR) && (ls_hr_i <= MAX_DIGIT) &&
                   ((ms_hr_i != MAX_MS_HR) || (ls_hr_i <= MAX_LS_HR_AT_20));
   assign min_ok = (ms_min_i <= MAX_MS_MIN) && (ls_min_i <= MAX_DIGIT);

   assign time_ok_o = hr_ok && min_ok;

endmodule

// File: rtl/alarm_entry_ctrl.sv
// Keypad HH:MM alarm entry: shift buffer, inactivity timeout and commit FSM.
// Define ALARM_ENTRY_VALIDATE_EN to reject illegal times and enable entry_error.
module alarm_entry_ctrl
   import alarm_clock_pkg::*;
#(
   parameter int unsigned TIMEOUT_SEC = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       one_second,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       key_clear,
   input  logic       alarm_button,
   output logic [3:0] new_alarm_ms_hr,
   output logic [3:0] new_alarm_ls_hr,
   output logic [3:0] new_alarm_ms_min,
   output logic [3:0] new_alarm_ls_min,
   output logic       load_new_alarm,
   output logic       entry_active,
   output logic       entry_error
);

   localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT_SEC);

   entry_state_e     state_q, state_d;
   logic [3:0][3:0]  digits_q, digits_d;  // [3] = ms_hr ... [0] = ls_min
   logic [7:0]       secs_q, secs_d;
   logic             key_ok;
   logic             expired;
   logic             shift;
   logic             clear;

   assign key_ok  = key_valid && (key_digit <= MAX_DIGIT);
   assign expired = (secs_q == TimeoutCnt);

`ifdef ALARM_ENTRY_VALIDATE_EN
   logic time_ok;
   logic err_q, err_d;

   hhmm_validator u_validator (
      .ms_hr_i   (digits_q[3]),
      .ls_hr_i   (digits_q[2]),
      .ms_min_i  (digits_q[1]),
      .ls_min_i  (digits_q[0]),
      .time_ok_o (time_ok)
   );

   assign entry_error = err_q;
`else
   assign entry_error = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      shift   = 1'b0;
      clear   = 1'b0;
`ifdef ALARM_ENTRY_VALIDATE_EN
      err_d   = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (key_ok) begin
               shift   = 1'b1;
               state_d = StEntry;
            end
         end
         StEntry: begin
            if (key_clear || expired) begin
               clear   = 1'b1;
               state_d = StIdle;
            end else if (alarm_button) begin
`ifdef ALARM_ENTRY_VALIDATE_EN
               if (time_ok) begin
                  state_d = StCommit;
               end else begin
                  err_d   = 1'b1;
                  clear   = 1'b1;
                  state_d = StIdle;
               end
`else
               state_d = StCommit;
`endif
            end else if (key_ok) begin
               shift = 1'b1;
            end
         end
         StCommit: begin
            clear   = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      digits_d = digits_q;
      if (clear) begin
         digits_d = '0;
      end else if (shift) begin
         digits_d = {digits_q[2:0], key_digit};
      end

      // Count only idle seconds spent in ENTRY; any accepted key restarts it.
      secs_d = secs_q;
      if ((state_d != StEntry) || shift) begin
         secs_d = '0;
      end else if (one_second) begin
         secs_d = secs_q + 8'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         digits_q <= '0;
         secs_q   <= '0;
`ifdef ALARM_ENTRY_VALIDATE_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         digits_q <= digits_d;
         secs_q   <= secs_d;
`ifdef ALARM_ENTRY_VALIDATE_EN
         err_q    <= err_d;
`endif
      end
   end

   assign new_alarm_ms_hr  = digits_q[3];
   assign new_alarm_ls_hr  = digits_q[2];
   assign new_alarm_ms_min = digits_q[1];
   assign new_alarm_ls_min = digits_q[0];
   assign load_new_alarm   = (state_q == StCommit);
   assign entry_active     = (state_q == StEntry);

endmodule

// File: tb/tb_alarm_entry_ctrl.sv
// Self-checking bench for alarm_entry_ctrl: directed scenarios plus a randomized
// run against a decimal-arithmetic model of the entry buffer.
module tb_alarm_entry_ctrl;

   localparam int unsigned TO = 3;
`ifdef ALARM_ENTRY_VALIDATE_EN
   localparam bit Validate = 1'b1;
`else
   localparam bit Validate = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       one_second;
   logic       key_valid;
   logic [3:0] key_digit;
   logic       key_clear;
   logic       alarm_button;
   logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
   logic       load_new_alarm;
   logic       entry_active;
   logic       entry_error;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: buffer held as a 4-digit decimal number
   int m_num;
   bit m_entry, m_commit, m_err;
   int m_secs;

   always #5 clock = ~clock;

   alarm_entry_ctrl #(
      .TIMEOUT_SEC (TO)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .one_second       (one_second),
      .key_valid        (key_valid),
      .key_digit        (key_digit),
      .key_clear        (key_clear),
      .alarm_button     (alarm_button),
      .new_alarm_ms_hr  (ms_hr),
      .new_alarm_ls_hr  (ls_hr),
      .new_alarm_ms_min (ms_min),
      .new_alarm_ls_min (ls_min),
      .load_new_alarm   (load_new_alarm),
      .entry_active     (entry_active),
      .entry_error      (entry_error)
   );

   function automatic logic [15:0] digits();
      return {ms_hr, ls_hr, ms_min, ls_min};
   endfunction

   // One clock with the given inputs; returns #1 after the rising edge.
   task automatic cyc(input bit kv, input int kd, input bit clr, input bit btn,
                      input bit tick);
      key_valid    = kv;
      key_digit    = 4'(kd);
      key_clear    = clr;
      alarm_button = btn;
      one_second   = tick;
      @(posedge clock);
      #1;
      key_valid    = 1'b0;
      key_digit    = 4'd0;
      key_clear    = 1'b0;
      alarm_button = 1'b0;
      one_second   = 1'b0;
   endtask

   task automatic key(input int d);
      cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      idle(1);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      n_cmp++;
      if ({digits(), load_new_alarm, entry_active, entry_error} !== 19'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h want 0",
                  {digits(), load_new_alarm, entry_active, entry_error});
      end
      apply_reset();
   endtask

   task automatic test_commit_basic();
      key(1);
      n_cmp++;
      if (entry_active !== 1'b1 || digits() !== 16'h0001) begin
         n_bad++;
         $display("FAIL first_key: active %b digits %h want 1 0001", entry_active, digits());
      end
      key(2); key(3); key(4);
      cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (load_new_alarm !== 1'b1 || digits() !== 16'h1234 || entry_active !== 1'b0) begin
         n_bad++;
         $display("FAIL commit_1234: load %b digits %h active %b want 1 1234 0",
                  load_new_alarm, digits(), entry_active);
      end
      idle(1);
      n_cmp++;
      if (load_new_alarm !== 1'b0) begin
         n_bad++;
         $display("FAIL load_one_cycle: load %b want 0", load_new_alarm);
      end
      idle(1);
      n_cmp++;
      if (digits() !== 16'h0000 || entry_active !== 1'b0) begin
         n_bad++;
         $display("FAIL post_commit_clear: digits %h active %b want 0000 0",
                  digits(), entry_active);
      end
   endtask

   task automatic test_short_and_long();
      key(7); key(3); key(0);
      cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (load_new_alarm !== 1'b1 || digits() !== 16'h0730) begin
         n_bad++;
         $display("FAIL commit_0730: load %b digits %h want 1 0730", load_new_alarm, digits());
      end
      idle(2);
      for (int d = 1; d <= 5; d++) key(d);
      cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (load_new_alarm !== 1'b1 || digits() !== 16'h2345) begin
         n_bad++;
         $display("FAIL commit_2345: load %b digits %h want 1 2345", load_new_alarm, digits());
      end
      idle(2);
   endtask

   task automatic test_invalid_time();
      key(2); key(4); key(0); key(0);
      cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (Validate) begin
         if (entry_error !== 1'b1 || load_new_alarm !== 1'b0 || digits() !== 16'h0000) begin
            n_bad++;
            $display("FAIL reject_2400: err %b load %b digits %h want 1 0 0000",
                     entry_error, load_new_alarm, digits());
         end
      end else begin
         if (entry_error !== 1'b0 || load_new_alarm !== 1'b1 || digits() !== 16'h2400) begin
            n_bad++;
            $display("FAIL accept_2400: err %b load %b digits %h want 0 1 2400",
                     entry_error, load_new_alarm, digits());
         end
      end
      idle(1);
      n_cmp++;
      if (entry_error !== 1'b0 || load_new_alarm !== 1'b0) begin
         n_bad++;
         $display("FAIL strobes_drop: err %b load %b want 0 0", entry_error, load_new_alarm);
      end
      idle(1);
   endtask

   task automatic test_timeout();
      key(5);
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b1); idle(1);
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b1); idle(1);
      n_cmp++;
      if (entry_active !== 1'b1 || digits() !== 16'h0005) begin
         n_bad++;
         $display("FAIL before_timeout: active %b digits %h want 1 0005", entry_active, digits());
      end
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b1); idle(2);
      n_cmp++;
      if (entry_active !== 1'b0 || digits() !== 16'h0000) begin
         n_bad++;
         $display("FAIL timeout_expiry: active %b digits %h want 0 0000", entry_active, digits());
      end
      // Key arriving with tick 2 restarts the count
      key(5);
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 6, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b1); idle(1);
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b1); idle(3);
      n_cmp++;
      if (entry_active !== 1'b1 || digits() !== 16'h0056) begin
         n_bad++;
         $display("FAIL timeout_restart: active %b digits %h want 1 0056", entry_active, digits());
      end
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b1); idle(2);
      n_cmp++;
      if (entry_active !== 1'b0 || digits() !== 16'h0000) begin
         n_bad++;
         $display("FAIL timeout_after_restart: active %b digits %h want 0 0000",
                  entry_active, digits());
      end
   endtask

   task automatic test_clear_and_bad_key();
      key(1); key(2); key(3); key(4);
      cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (digits() !== 16'h0000 || entry_active !== 1'b0 || load_new_alarm !== 1'b0) begin
         n_bad++;
         $display("FAIL clear_beats_button: digits %h active %b load %b want 0000 0 0",
                  digits(), entry_active, load_new_alarm);
      end
      idle(1);
      n_cmp++;
      if (load_new_alarm !== 1'b0) begin
         n_bad++;
         $display("FAIL no_late_load: load %b want 0", load_new_alarm);
      end
      key(12);
      n_cmp++;
      if (entry_active !== 1'b0 || digits() !== 16'h0000) begin
         n_bad++;
         $display("FAIL bad_key_idle: active %b digits %h want 0 0000", entry_active, digits());
      end
      key(8); key(12);
      n_cmp++;
      if (entry_active !== 1'b1 || digits() !== 16'h0008) begin
         n_bad++;
         $display("FAIL bad_key_entry: active %b digits %h want 1 0008", entry_active, digits());
      end
      cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
      idle(1);
   endtask

   task automatic test_reset_in_commit();
      key(1); key(2); key(3); key(4);
      cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({digits(), load_new_alarm, entry_active, entry_error} !== 19'd0) begin
         n_bad++;
         $display("FAIL reset_in_commit: got %h want 0",
                  {digits(), load_new_alarm, entry_active, entry_error});
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
      idle(1);
   endtask

   task automatic model_step(input bit kv, input int kd, input bit clr, input bit btn,
                             input bit tick);
      bit key_ok;
      key_ok = kv && (kd <= 9);
      m_err  = 1'b0;
      if (m_commit) begin
         m_commit = 1'b0;
         m_num    = 0;
      end else if (!m_entry) begin
         if (key_ok) begin
            m_num   = (m_num * 10 + kd) % 10000;
            m_entry = 1'b1;
            m_secs  = 0;
         end
      end else if (clr || m_secs == int'(TO)) begin
         m_num   = 0;
         m_entry = 1'b0;
         m_secs  = 0;
      end else if (btn) begin
         m_entry = 1'b0;
         m_secs  = 0;
         if (!Validate || ((m_num / 100) < 24 && (m_num % 100) < 60)) begin
            m_commit = 1'b1;
         end else begin
            m_err = 1'b1;
            m_num = 0;
         end
      end else if (key_ok) begin
         m_num  = (m_num * 10 + kd) % 10000;
         m_secs = 0;
      end else if (tick) begin
         m_secs++;
      end
   endtask

   task automatic test_random();
      logic [18:0] exp_v, got_v;
      int          shown = 0;
      apply_reset();
      m_num = 0; m_entry = 0; m_commit = 0; m_err = 0; m_secs = 0;
      for (int i = 0; i < 3000; i++) begin
         bit kv, clr, btn, tick;
         int kd;
         kv   = ($urandom % 3) == 0;
         kd   = (($urandom % 5) == 0) ? int'($urandom_range(15, 10)) : int'($urandom_range(9, 0));
         clr  = ($urandom % 40) == 0;
         btn  = ($urandom % 8) == 0;
         tick = ($urandom % 4) == 0;
         model_step(kv, kd, clr, btn, tick);
         cyc(kv, kd, clr, btn, tick);
         exp_v = {4'(m_num / 1000), 4'((m_num / 100) % 10), 4'((m_num / 10) % 10),
                  4'(m_num % 10), m_commit, m_entry, m_err};
         got_v = {digits(), load_new_alarm, entry_active, entry_error};
         n_cmp++;
         if (got_v !== exp_v) begin
            n_bad++;
            if (shown < 10) begin
               shown++;
               $display("FAIL random_cycle_%0d: got %h want %h (digits,load,active,err)",
                        i, got_v, exp_v);
            end
         end
      end
   endtask

   initial begin
      reset        = 1'b0;
      one_second   = 1'b0;
      key_valid    = 1'b0;
      key_digit    = 4'd0;
      key_clear    = 1'b0;
      alarm_button = 1'b0;
      test_reset();
      test_commit_basic();
      test_short_and_long();
      test_invalid_time();
      test_timeout();
      test_clear_and_bad_key();
      test_reset_in_commit();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
